// File: rtl/pe_tile_pkg.sv
// pe_tile_pkg: shared defaults, state types and PE indexing for the tile loader
package pe_tile_pkg;
  localparam int DW_DEF = 8;
  localparam int K_DEF = 3;
  localparam int HOLD_DEF = 6;
  typedef enum logic {LD_LOAD, LD_FULL} loader_state_e;
  typedef enum logic {OUT_IDLE, OUT_HOLD} out_state_e;
  function automatic int pe_idx(int r, int c);
    return r * K_DEF + c;
  endfunction
endpackage

// File: rtl/pe_tile_loader_if.sv
// pe_tile_loader_if: row-beat input handshake plus PE-facing tile outputs
interface pe_tile_loader_if import pe_tile_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int K = K_DEF
);
  logic in_valid;
  logic in_ready;
  logic [K*DW-1:0] in_data;
  logic [K*DW-1:0] in_wt;
  logic [K*K*DW-1:0] data_pe;
  logic [K*K*DW-1:0] wt_pe;
  logic out_valid;
  logic tile_start;
  modport master (output in_valid, in_data, in_wt, input in_ready, data_pe, wt_pe, out_valid, tile_start);
  modport slave (input in_valid, in_data, in_wt, output in_ready, data_pe, wt_pe, out_valid, tile_start);
endinterface

// File: rtl/pe_tile_shadow.sv
// pe_tile_shadow: KxK data/weight register bank with a row write port and full-tile read
module pe_tile_shadow #(
  parameter int DW = 8,
  parameter int K = 3,
  parameter int RW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [RW-1:0] row,
  input  logic [K*DW-1:0] row_data,
  input  logic [K*DW-1:0] row_wt,
  output logic [K*K*DW-1:0] tile_data,
  output logic [K*K*DW-1:0] tile_wt
);
  logic [DW-1:0] d_q [K*K];
  logic [DW-1:0] w_q [K*K];
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      // column 0 arrives in the MSBs of the row beat
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          d_q[r*K+c] <= '0;
          w_q[r*K+c] <= '0;
        end else if (we && row == RW'(r)) begin
          d_q[r*K+c] <= row_data[(K-1-c)*DW +: DW];
          w_q[r*K+c] <= row_wt[(K-1-c)*DW +: DW];
        end
      end
      assign tile_data[(r*K+c)*DW +: DW] = d_q[r*K+c];
      assign tile_wt[(r*K+c)*DW +: DW] = w_q[r*K+c];
    end
  end
endmodule

// File: rtl/pe_tile_loader.sv
// pe_tile_loader: double-buffered row loader feeding a held KxK tile to the PE array
module pe_tile_loader import pe_tile_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int K = K_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  pe_tile_loader_if.slave bus
);
  localparam int CW = K > 1 ? $clog2(K) : 1;
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  loader_state_e ld_st;
  out_state_e out_st;
  logic [CW-1:0] row_cnt;
  logic [HW-1:0] hold_cnt;
  logic [K*K*DW-1:0] sh_data, sh_wt;
  logic accept, xfer, row_last, hold_last;
  assign bus.in_ready = ld_st == LD_LOAD;
  assign accept = bus.in_valid && ld_st == LD_LOAD;
  assign row_last = row_cnt == CW'(K - 1);
  assign hold_last = hold_cnt == HW'(HOLD - 1);
  assign xfer = ld_st == LD_FULL && (out_st == OUT_IDLE || hold_last);
  // rows fill bottom-first: beat n lands in row K-1-n
  pe_tile_shadow #(.DW(DW), .K(K), .RW(CW)) u_shadow (
    .clk(clk),
    .rst_n(rst_n),
    .we(accept && !flush),
    .row(CW'(K - 1) - row_cnt),
    .row_data(bus.in_data),
    .row_wt(bus.in_wt),
    .tile_data(sh_data),
    .tile_wt(sh_wt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      ld_st <= LD_LOAD;
      out_st <= OUT_IDLE;
      row_cnt <= '0;
      hold_cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.tile_start <= 1'b0;
      bus.data_pe <= '0;
      bus.wt_pe <= '0;
    end else if (xfer) begin
      ld_st <= LD_LOAD;
      row_cnt <= '0;
      out_st <= OUT_HOLD;
      hold_cnt <= '0;
      bus.out_valid <= 1'b1;
      bus.tile_start <= 1'b1;
      bus.data_pe <= sh_data;
      bus.wt_pe <= sh_wt;
    end else begin
      bus.tile_start <= 1'b0;
      if (accept) begin
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        ld_st <= row_last ? LD_FULL : LD_LOAD;
      end
      if (out_st == OUT_HOLD) begin
        hold_cnt <= hold_last ? '0 : hold_cnt + 1'b1;
        if (hold_last) begin
          out_st <= OUT_IDLE;
          bus.out_valid <= 1'b0;
          bus.data_pe <= '0;
          bus.wt_pe <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_tile_loader.sv
// tb_pe_tile_loader: directed tiles checked against a queue-level model and literal tiles
module tb_pe_tile_loader;
  import pe_tile_pkg::*;
  localparam int DW = 8, K = 3, HOLD = 6, N = K * K;
  localparam logic [N*DW-1:0] TA_D = 72'h030201060504090807;
  localparam logic [N*DW-1:0] TA_W = 72'hFCFDFEF9FAFBF6F7F8;
  localparam logic [N*DW-1:0] TB_D = 72'h0C0B0A0F0E0D121110;
  localparam logic [N*DW-1:0] TB_W = 72'hF3F4F5F0F1F2EDEEEF;
  logic clk = 0, rst_n = 0, flush = 0;
  pe_tile_loader_if #(.DW(DW), .K(K)) bus ();
  pe_tile_loader #(.DW(DW), .K(K), .HOLD(HOLD)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  int vec = 0, miss = 0, cyc = 0;
  int run = 0, last_run = 0;
  int ts_q[$];
  bit saw_block = 0, m_on = 0;
  function automatic void chk(string name, logic [N*DW-1:0] act, logic [N*DW-1:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction
  function automatic void chkb(string name, logic act, logic exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endfunction
  function automatic void chki(string name, int act, int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction
  function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a[N]);
    logic [N*DW-1:0] v;
    for (int p = 0; p < N; p++) v[p*DW +: DW] = a[p];
    return v;
  endfunction
  // model: partial tile, one complete tile waiting, and the tile on display with cycles left
  logic [DW-1:0] m_part_d[N], m_part_w[N], m_pend_d[N], m_pend_w[N], m_out_d[N], m_out_w[N];
  bit m_pend = 0, m_start = 0, m_acc;
  int m_n = 0, m_remain = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n || flush) begin
      m_pend = 0; m_n = 0; m_remain = 0; m_start = 0;
      for (int p = 0; p < N; p++) begin m_out_d[p] = 0; m_out_w[p] = 0; end
    end else begin
      m_acc = bus.in_valid && !m_pend;
      m_start = 0;
      if (m_pend && m_remain <= 1) begin
        m_out_d = m_pend_d; m_out_w = m_pend_w;
        m_remain = HOLD; m_start = 1; m_pend = 0;
      end else if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0)
          for (int p = 0; p < N; p++) begin m_out_d[p] = 0; m_out_w[p] = 0; end
      end
      if (m_acc) begin
        for (int c = 0; c < K; c++) begin
          m_part_d[pe_idx(K-1-m_n, c)] = bus.in_data[(K-1-c)*DW +: DW];
          m_part_w[pe_idx(K-1-m_n, c)] = bus.in_wt[(K-1-c)*DW +: DW];
        end
        m_n++;
        if (m_n == K) begin
          m_pend_d = m_part_d; m_pend_w = m_part_w; m_pend = 1; m_n = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (m_on) begin
      chkb("in_ready", bus.in_ready, !m_pend);
      chkb("out_valid", bus.out_valid, m_remain > 0);
      chkb("tile_start", bus.tile_start, m_start);
      chk("data_pe", bus.data_pe, pack(m_out_d));
      chk("wt_pe", bus.wt_pe, pack(m_out_w));
    end
    if (bus.tile_start) ts_q.push_back(cyc);
    if (bus.in_valid && !bus.in_ready) saw_block = 1;
    if (bus.out_valid) run++;
    else if (run > 0) begin last_run = run; run = 0; end
  end
  task automatic beat(input logic [K*DW-1:0] d);
    int n = 0;
    bit ok = 0;
    bus.in_valid = 1; bus.in_data = d; bus.in_wt = ~d;
    while (!ok && n < 50) begin
      ok = bus.in_ready;
      @(negedge clk);
      n++;
    end
    chkb("beat_accept", ok, 1'b1);
  endtask
  task automatic tile(input logic [K*DW-1:0] r0, input logic [K*DW-1:0] r1, input logic [K*DW-1:0] r2);
    beat(r0); beat(r1); beat(r2);
    bus.in_valid = 0;
  endtask
  task automatic wait_start(input int cnt);
    int n = 0;
    while (ts_q.size() < cnt && n < 50) begin @(negedge clk); n++; end
    chkb("start_seen", ts_q.size() >= cnt, 1'b1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.out_valid && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    chkb("idle_reached", bus.out_valid, 1'b0);
  endtask
  initial begin
    int f, e;
    bus.in_valid = 0; bus.in_data = 0; bus.in_wt = 0;
    repeat (3) @(negedge clk);
    m_on = 1;
    rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_data", bus.data_pe, '0);
    chk("idle_wt", bus.wt_pe, '0);
    chkb("idle_valid", bus.out_valid, 1'b0);
    chkb("idle_ready", bus.in_ready, 1'b1);
    // single tile
    ts_q.delete();
    beat(24'h010203); f = cyc; beat(24'h040506); beat(24'h070809); bus.in_valid = 0;
    e = cyc;
    chkb("lat_after_e", bus.out_valid, 1'b0);
    @(negedge clk);
    chkb("lat_after_e1", bus.out_valid, 1'b1);
    chkb("first_start", bus.tile_start, 1'b1);
    chk("tile_a_data", bus.data_pe, TA_D);
    chk("tile_a_wt", bus.wt_pe, TA_W);
    wait_idle();
    chki("hold_len", last_run, HOLD);
    chki("start_after_first", ts_q[0] - f, 3);
    chki("start_after_last", ts_q[0] - e, 1);
    chk("expired_data", bus.data_pe, '0);
    chk("expired_wt", bus.wt_pe, '0);
    // gapped input
    ts_q.delete();
    beat(24'h010203); f = cyc; beat(24'h040506); bus.in_valid = 0;
    repeat (4) @(negedge clk);
    beat(24'h070809); bus.in_valid = 0;
    wait_start(1);
    chki("gap_delay", ts_q[0] - f, 7);
    chk("gap_data", bus.data_pe, TA_D);
    chk("gap_wt", bus.wt_pe, TA_W);
    wait_idle();
    // back-to-back
    ts_q.delete(); saw_block = 0;
    beat(24'h010203); beat(24'h040506); beat(24'h070809);
    beat(24'h0A0B0C); beat(24'h0D0E0F); beat(24'h101112); bus.in_valid = 0;
    wait_start(2);
    chki("b2b_spacing", ts_q[1] - ts_q[0], HOLD);
    chk("b2b_data", bus.data_pe, TB_D);
    chk("b2b_wt", bus.wt_pe, TB_W);
    wait_idle();
    chki("b2b_valid_run", last_run, 2 * HOLD);
    chkb("b2b_ready_low", saw_block, 1'b1);
    // flush during the third beat, then during a hold
    ts_q.delete();
    beat(24'h010203); beat(24'h040506);
    bus.in_valid = 1; bus.in_data = 24'h070809; bus.in_wt = ~24'h070809; flush = 1;
    @(negedge clk);
    flush = 0; bus.in_valid = 0;
    chkb("flush_ready", bus.in_ready, 1'b1);
    chkb("flush_valid", bus.out_valid, 1'b0);
    tile(24'h0A0B0C, 24'h0D0E0F, 24'h101112);
    wait_start(1);
    chk("post_flush_data", bus.data_pe, TB_D);
    chk("post_flush_wt", bus.wt_pe, TB_W);
    repeat (2) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chkb("hold_flush_valid", bus.out_valid, 1'b0);
    chk("hold_flush_data", bus.data_pe, '0);
    // reset mid-hold with a beat offered
    ts_q.delete();
    tile(24'h010203, 24'h040506, 24'h070809);
    wait_start(1);
    repeat (2) @(negedge clk);
    bus.in_valid = 1; bus.in_data = 24'h0A0B0C; bus.in_wt = ~24'h0A0B0C; rst_n = 0;
    @(negedge clk);
    chkb("rst_valid", bus.out_valid, 1'b0);
    chkb("rst_start", bus.tile_start, 1'b0);
    chk("rst_data", bus.data_pe, '0);
    chk("rst_wt", bus.wt_pe, '0);
    chkb("rst_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1; bus.in_valid = 0;
    @(negedge clk);
    ts_q.delete();
    tile(24'h0A0B0C, 24'h0D0E0F, 24'h101112);
    wait_start(1);
    chk("post_rst_data", bus.data_pe, TB_D);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/pe_tile_loader.md
# pe_tile_loader

- Parametrised, double-buffered input loader for the K×K processing-element array.
- Accepts one row of K data bytes and K weight bytes per handshake beat, and assembles K rows into a shadow tile.
- Moves the complete tile into the PE-facing output registers, holds it valid for HOLD cycles, then zeroes it.
- The next tile loads while the current tile is held, so the array can be fed back to back.

## Interface
- DW, 8: bits per data/weight element.
- K, 3: array side; the tile is K×K PEs and each beat carries K elements.
- HOLD, 6: cycles a transferred tile stays on the outputs (legal range ≥1).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous abort: discards any partial or held tile.
- in_valid  in  1  row beat present.
- in_ready  out  1  loader can accept a beat.
- in_data  in  K*DW  row of data; column c at [(K-1-c)*DW +: DW], so column 0 is in the MSBs.
- in_wt  in  K*DW  row of weights, same packing as in_data.
- data_pe  out  K*K*DW  PE p = r*K+c at [p*DW +: DW].
- wt_pe  out  K*K*DW  same packing as data_pe.
- out_valid  out  1  data_pe/wt_pe hold a valid tile.
- tile_start  out  1  one-cycle pulse on the first cycle of each new tile on the outputs.

## Operation
**Loader FSM**
- States: LOAD (row_cnt 0..K-1) and FULL.
- A beat is accepted when in_valid && in_ready.
- Beat n (n = 0..K-1) of a tile is written to shadow row K-1-n, so rows fill bottom-first.
- After beat K-1 the FSM goes to FULL.
- in_ready = (state == LOAD). It is a registered-state decode and has no combinational path from in_valid.

**Output FSM**
- States: IDLE and HOLD, with hold_cnt counting 0..HOLD-1.
- A transfer copies the shadow tile into data_pe/wt_pe, sets out_valid, pulses tile_start, clears hold_cnt, and returns the loader to LOAD with row_cnt=0.
- Transfer condition: loader FULL and (output IDLE, or output in HOLD with hold_cnt == HOLD-1).
- If HOLD expires with no tile waiting: out_valid goes low, data_pe and wt_pe go to all zeros, and the output FSM returns to IDLE.
- Outputs never show a partially loaded tile.

**Boundary conditions**
- in_valid low mid-tile: row_cnt holds and the partial tile is kept indefinitely.
- Beats offered while FULL are not accepted (in_ready=0). The source must hold them.
- flush: row_cnt=0, loader goes to LOAD, output goes to IDLE, out_valid=0, data_pe/wt_pe=0. The shadow contents are don't-care.
- flush has priority over a transfer or beat acceptance in the same cycle.
- rst_n low: same effect as flush, and the shadow registers also clear to 0.

**Reset values**
- in_ready=1, out_valid=0, tile_start=0, data_pe=0, wt_pe=0.

## Timing
- Last beat of a tile accepted at edge E: FULL from E. If output is IDLE, transfer at edge E+1.
  - out_valid and tile_start are high after E+1.
  - out_valid stays high through E+HOLD and falls at edge E+1+HOLD unless a back-to-back transfer occurs.
- Minimum beat-to-output latency: 2 cycles after the last beat is presented.
- Back-to-back: a new tile transfers on the same edge the old hold expires.
  - out_valid stays continuously high.
  - tile_start pulses again.
- Sustained throughput:
  - One tile per max(K+1, HOLD) cycles.
  - The loader spends one cycle in FULL when HOLD ≤ K+1.
- in_ready rises the cycle after the transfer edge.

## Structure
- Package pe_tile_pkg holds:
  - Defaults: DW, K, HOLD.
  - Helper function pe_idx(r,c) = r*K+c.
  - Typedefs: loader_state_e {LOAD, FULL} and out_state_e {IDLE, HOLD}.
- Counter widths: $clog2(K) and $clog2(HOLD) with minimum 1 bit.
- One sub-module, pe_tile_shadow: K×K×2 register bank with a row write port (row index + K-element row) and a full-tile read.
- Top level holds both FSMs, hold_cnt, and the output registers.

## Test plan
All scenarios use K=3, DW=8, HOLD=6.
- Reset then idle: after rst_n deasserts, data_pe=0, wt_pe=0, out_valid=0, in_ready=1.
- Single tile, beats in_data = 0x010203, 0x040506, 0x070809 with in_wt = in_data^0xFF:
  - Expect PE6..8 = 01,02,03; PE3..5 = 04,05,06; PE0..2 = 07,08,09.
  - out_valid high for exactly 6 cycles starting 2 cycles after the last beat, then all outputs zero.
- Gapped input: in_valid deasserted for 4 cycles between beats 1 and 2.
  - Same tile contents; out_valid delayed by exactly 4 cycles.
- Back-to-back, in_valid always high with two tiles A and B:
  - in_ready low while FULL.
  - out_valid continuously high for 12 cycles; tile_start pulses twice, 6 cycles apart; contents switch from A to B on the second pulse.
- flush during beat 2 of a tile and during a HOLD: outputs zero and out_valid=0 on the next cycle; the following full tile loads correctly from row 2.
- rst_n asserted mid-HOLD with in_valid high: the next cycle shows reset values, and no beat is accepted during reset.
